// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
//
// Single-ported 32-bit data memory that answers a valid/ready request with
// a one-cycle response strobe after a fixed number of wait states.
//
// Parameters
//   DEPTH_WORDS  number of 32-bit words (power of two, 16..4096)
//   WAIT_CYCLES  extra wait states per access (0..15)
//
// Ports
//   clk        clock, all state updates on the rising edge
//   reset      asynchronous, active-low reset
//   req_valid  initiator presents a request
//   req_ready  responder accepts a request this cycle (IDLE only)
//   req_addr   byte address, word index = req_addr[log2(DEPTH_WORDS)+1:2]
//   req_we     lane-aligned byte write enables, 4'b0000 = read
//   req_wdata  lane-aligned write data
//   rsp_valid  one-cycle response strobe
//   rsp_rdata  read word, 0 for writes / errored accesses / no response
//   rsp_err    access error, qualified by rsp_valid
//
// Optional feature
//   DMEM_BOUNDS_CHECK_EN  when defined, accesses with req_addr[31:2] beyond
//                         DEPTH_WORDS report rsp_err and suppress the write;
//                         when undefined the index wraps and rsp_err is 0.
// ---------------------------------------------------------------------------
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [3:0]  req_we,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [AW-1:0]  idx_q;
    logic [3:0]     we_q;
    logic [31:0]    wdata_q;
    logic           err_q;

    logic [31:0]    mem_q [DEPTH_WORDS];
    logic [31:0]    rd_word_q;

    logic           accept;
    logic           in_err;
    logic           enter_resp;
    logic [AW-1:0]  eff_idx;
    logic [3:0]     eff_we;
    logic [31:0]    eff_wdata;
    logic           eff_err;

    // Low address bits (and, without bounds checking, the upper bits) carry
    // no meaning for the word index.
    logic           unused_addr;
    assign unused_addr = ^{req_addr[31:AW+2], req_addr[1:0]};

    assign req_ready = (state_q == IDLE);
    // Gating with reset keeps a request seen while reset is held from
    // touching storage.
    assign accept    = req_valid && req_ready && reset;

`ifdef DMEM_BOUNDS_CHECK_EN
    assign in_err = (req_addr[31:2] >= 30'(DEPTH_WORDS));
`else
    assign in_err = 1'b0;
`endif

    // With zero wait states the access happens on the accept edge itself,
    // so the live request fields are used; otherwise the captured copy.
    assign eff_idx   = (state_q == IDLE) ? req_addr[AW+1:2] : idx_q;
    assign eff_we    = (state_q == IDLE) ? req_we           : we_q;
    assign eff_wdata = (state_q == IDLE) ? req_wdata        : wdata_q;
    assign eff_err   = (state_q == IDLE) ? in_err           : err_q;

    // Edge on which the FSM moves into RESP: memory is read/written here.
    assign enter_resp = reset &&
                        (((state_q == IDLE) && accept && (WAIT_CYCLES == 0)) ||
                         ((state_q == WAIT) && (cnt_q == 4'd0)));

    // -----------------------------------------------------------------------
    // FSM next state
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (WAIT_CYCLES > 0) begin
                        state_d = WAIT;
                        cnt_d   = WAIT_LOAD;
                    end else begin
                        state_d = RESP;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State, counter and request capture
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            we_q    <= 4'd0;
            wdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                idx_q   <= req_addr[AW+1:2];
                we_q    <= req_we;
                wdata_q <= req_wdata;
                err_q   <= in_err;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Storage: no reset, byte-lane writes, registered read
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (enter_resp) begin
            rd_word_q <= mem_q[eff_idx];
            if (!eff_err) begin
                for (int i = 0; i < 4; i++) begin
                    if (eff_we[i]) begin
                        mem_q[eff_idx][8*i +: 8] <= eff_wdata[8*i +: 8];
                    end
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Response: data and error are forced to 0 outside the strobe
    // -----------------------------------------------------------------------
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = (rsp_valid && (we_q == 4'd0) && !err_q) ? rd_word_q : 32'd0;
    assign rsp_err   = rsp_valid && err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// ---------------------------------------------------------------------------
// tb_dmem_responder
//
// Two responders side by side (0 and 3 wait states) driven by directed and
// randomized accesses; expected data comes from a word-array model that
// applies the byte-lane write rules, and expected timing from the wait count.
// ---------------------------------------------------------------------------
module tb_dmem_responder;

`ifdef DMEM_BOUNDS_CHECK_EN
    localparam bit BOUNDS = 1'b1;
`else
    localparam bit BOUNDS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset     [2];
    logic        req_valid [2];
    logic        req_ready [2];
    logic [31:0] req_addr  [2];
    logic [3:0]  req_we    [2];
    logic [31:0] req_wdata [2];
    logic        rsp_valid [2];
    logic [31:0] rsp_rdata [2];
    logic        rsp_err   [2];

    logic [31:0] model_mem [2][256];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        dmem_responder #(
            .DEPTH_WORDS (256),
            .WAIT_CYCLES (gi * 3)
        ) u_dut (
            .clk       (clk),
            .reset     (reset[gi]),
            .req_valid (req_valid[gi]),
            .req_ready (req_ready[gi]),
            .req_addr  (req_addr[gi]),
            .req_we    (req_we[gi]),
            .req_wdata (req_wdata[gi]),
            .rsp_valid (rsp_valid[gi]),
            .rsp_rdata (rsp_rdata[gi]),
            .rsp_err   (rsp_err[gi])
        );
    end

    function automatic int wait_of(input int d);
        return d * 3;
    endfunction

    task automatic check(input string name, input int d, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s dut%0d observed=%h expected=%h", name, d, obs, exp_v);
        end
    endtask

    // One access, started at #1 after an edge with the DUT idle; returns at
    // #1 after the edge that ends the response.
    task automatic xact(input int d, input logic [31:0] addr, input logic [3:0] we,
                        input logic [31:0] wd, output logic [31:0] got);
        int          w;
        int          lat;
        int          idx;
        logic        err;
        logic [31:0] exp_rd;
        w   = wait_of(d);
        idx = int'((addr >> 2) % 256);
        err = BOUNDS && ((addr >> 2) >= 256);
        exp_rd = (we == 4'd0 && !err) ? model_mem[d][idx] : 32'd0;

        check("ready_idle", d, 32'(req_ready[d]), 32'd1);
        req_valid[d] = 1'b1;
        req_addr[d]  = addr;
        req_we[d]    = we;
        req_wdata[d] = wd;
        @(posedge clk); #1;
        // Scramble the request fields: the DUT must use what it captured.
        req_valid[d] = 1'b0;
        req_addr[d]  = $urandom;
        req_we[d]    = 4'($urandom);
        req_wdata[d] = $urandom;
        lat = 0;
        while (rsp_valid[d] !== 1'b1 && lat < 20) begin
            check("ready_busy", d, 32'(req_ready[d]), 32'd0);
            @(posedge clk); #1;
            lat++;
        end
        check("latency", d, 32'(lat), 32'(w));
        got = rsp_rdata[d];
        check("rdata", d, rsp_rdata[d], exp_rd);
        check("err", d, 32'(rsp_err[d]), 32'(err));
        check("ready_resp", d, 32'(req_ready[d]), 32'd0);
        if (we != 4'd0 && !err) begin
            for (int i = 0; i < 4; i++) begin
                if (we[i]) model_mem[d][idx][8*i +: 8] = wd[8*i +: 8];
            end
        end
        @(posedge clk); #1;
        check("rsp_drop", d, 32'(rsp_valid[d]), 32'd0);
        check("rdata_idle", d, rsp_rdata[d], 32'd0);
        check("ready_back", d, 32'(req_ready[d]), 32'd1);
        $display("xact dut%0d addr=%h we=%b wdata=%h rdata=%h lat=%0d", d, addr, we, wd, got, lat);
    endtask

    // req_valid held high with a new read address every cycle.
    task automatic stream(input int d, input int ncyc);
        logic [31:0] hist [64];
        int          w;
        int          s;
        logic        exp_v;
        logic [31:0] exp_rd;
        w = wait_of(d);
        for (int t = 0; t < ncyc; t++) begin
            hist[t]      = 32'($urandom_range(0, 31)) << 2;
            req_valid[d] = 1'b1;
            req_addr[d]  = hist[t];
            req_we[d]    = 4'd0;
            req_wdata[d] = $urandom;
            @(posedge clk); #1;
            s      = t;
            exp_v  = (s >= w) && (((s - w) % (w + 2)) == 0);
            exp_rd = exp_v ? model_mem[d][int'(hist[s - w] >> 2)] : 32'd0;
            check("stream_valid", d, 32'(rsp_valid[d]), 32'(exp_v));
            check("stream_rdata", d, rsp_rdata[d], exp_rd);
            $display("stream dut%0d cycle=%0d addr=%h rsp_valid=%0d rdata=%h", d, s, hist[t], rsp_valid[d], rsp_rdata[d]);
        end
        req_valid[d] = 1'b0;
        repeat (w + 3) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] got;
        logic [31:0] addr;
        logic [3:0]  we;
        int          d;

        for (int i = 0; i < 2; i++) begin
            reset[i]     = 1'b0;
            req_valid[i] = 1'b0;
            req_addr[i]  = 32'd0;
            req_we[i]    = 4'd0;
            req_wdata[i] = 32'd0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            check("rst_valid", i, 32'(rsp_valid[i]), 32'd0);
            check("rst_rdata", i, rsp_rdata[i], 32'd0);
            check("rst_err", i, 32'(rsp_err[i]), 32'd0);
            reset[i] = 1'b1;
        end
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++) check("rst_ready", i, 32'(req_ready[i]), 32'd1);

        // Preload words 0..31 of both memories.
        for (int i = 0; i < 2; i++) begin
            for (int wd = 0; wd < 32; wd++) xact(i, 32'(wd) << 2, 4'hF, $urandom, got);
        end

        // Full-word write then read back, zero wait states.
        xact(0, 32'h10, 4'hF, 32'hDEADBEEF, got);
        check("wr_rdata_zero", 0, got, 32'd0);
        xact(0, 32'h10, 4'h0, 32'h0, got);
        check("rd_deadbeef", 0, got, 32'hDEADBEEF);

        // Single byte lane merge.
        xact(0, 32'h20, 4'hF, 32'h11223344, got);
        xact(0, 32'h20, 4'b0100, 32'h00AA0000, got);
        xact(0, 32'h20, 4'h0, 32'h0, got);
        check("byte_merge", 0, got, 32'h11AA3344);

        // Three wait states: latency and ready checked inside xact.
        xact(1, 32'h20, 4'h0, 32'h0, got);
        xact(1, 32'h44, 4'b1001, 32'hA5000077, got);
        xact(1, 32'h44, 4'h0, 32'h0, got);

        // Back-to-back requests.
        stream(0, 16);
        stream(1, 30);

        // Reset during the wait states of a write aborts it.
        req_valid[1] = 1'b1;
        req_addr[1]  = 32'h30;
        req_we[1]    = 4'hF;
        req_wdata[1] = 32'h12345678;
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        @(posedge clk); #1;
        reset[1] = 1'b0;
        #2;
        check("abort_valid", 1, 32'(rsp_valid[1]), 32'd0);
        check("abort_rdata", 1, rsp_rdata[1], 32'd0);
        #1;
        reset[1] = 1'b1;
        for (int c = 0; c < wait_of(1) + 3; c++) begin
            @(posedge clk); #1;
            check("abort_norsp", 1, 32'(rsp_valid[1]), 32'd0);
            check("abort_ready", 1, 32'(req_ready[1]), 32'd1);
        end
        xact(1, 32'h30, 4'h0, 32'h0, got);
        $display("abort dut1 read 0x30 rdata=%h", got);

        // Out-of-range address 0x400 (word 256).
        for (int i = 0; i < 2; i++) begin
            xact(i, 32'h400, 4'hF, 32'hCAFEF00D, got);
            xact(i, 32'h400, 4'h0, 32'h0, got);
            xact(i, 32'h0, 4'h0, 32'h0, got);
            check("word0_after_oob", i, got, BOUNDS ? model_mem[i][0] : 32'hCAFEF00D);
        end

        // Randomized accesses.
        for (int n = 0; n < 60; n++) begin
            d    = int'($urandom_range(0, 1));
            addr = (32'($urandom_range(0, 31)) << 2) | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) addr = addr | ($urandom << 10);
            we   = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            xact(d, addr, we, $urandom, got);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
